// File: rtl/acc_pp2_sched_if.sv
// Handshake and adder-side bundle of the pipelined-accumulator scheduler.
// The slave side is the scheduler. The master side is the sample source and the shared adder.
interface acc_pp2_sched_if #(
    parameter int C_DW    = 16,
    parameter int C_SW    = 24,
    parameter int C_CNT_W = 10
);
    logic               I_start;
    logic [C_CNT_W-1:0] I_len;
    logic               I_vld;
    logic [C_DW-1:0]    I_data;
    logic               O_rdy;
    logic [C_SW-1:0]    O_add_a;
    logic [C_SW-1:0]    O_add_b;
    logic [C_SW-1:0]    I_add_sum;
    logic [C_SW-1:0]    O_sum;
    logic               O_sum_vld;
    logic               O_busy;

    modport slave (
        input  I_start, I_len, I_vld, I_data, I_add_sum,
        output O_rdy, O_add_a, O_add_b, O_sum, O_sum_vld, O_busy
    );

    modport master (
        output I_start, I_len, I_vld, I_data, I_add_sum,
        input  O_rdy, O_add_a, O_add_b, O_sum, O_sum_vld, O_busy
    );
endinterface

// File: rtl/acc_pp2_sched.sv
// Reduces a group of samples to one sum through a shared adder of latency C_LAT.
// C_LAT interleaved partial sums keep the adder busy every cycle; they are folded serially at the end.
module acc_pp2_sched #(
    parameter int C_DW    = 16,
    parameter int C_SW    = 24,
    parameter int C_LAT   = 2,
    parameter int C_CNT_W = 10
) (
    input  logic           I_clk,
    input  logic           I_rst,
    acc_pp2_sched_if.slave bus
);
    localparam int PW = (C_LAT > 1) ? $clog2(C_LAT) : 1;
    localparam logic [PW-1:0]      ZERO_IDX = {PW{1'b0}};
    localparam logic [PW-1:0]      ONE_IDX  = PW'(1);
    localparam logic [PW-1:0]      LAST_IDX = PW'(C_LAT - 1);
    localparam logic [C_CNT_W-1:0] CNT_ZERO = {C_CNT_W{1'b0}};
    localparam logic [C_CNT_W-1:0] CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_SW-1:0]    SUM_ZERO = {C_SW{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // With a single-cycle adder there is only one partial sum, so nothing to fold.
    localparam state_t AFTER_DRAIN = (C_LAT > 1) ? ST_FOLD : ST_DONE;

    function automatic logic [C_SW-1:0] sext(input logic [C_DW-1:0] d);
        return {{(C_SW - C_DW){d[C_DW-1]}}, d};
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [C_CNT_W-1:0] len_r;
    logic [C_CNT_W-1:0] cnt_r;
    logic [C_CNT_W-1:0] cnt_s;
    logic [PW-1:0]      slot_r;
    logic [PW-1:0]      slot_inc_s;
    logic [PW-1:0]      phase_r;
    logic [PW-1:0]      phase_inc_s;
    logic [PW-1:0]      fk_r;
    logic [C_LAT-1:0]   tag_r;
    logic [C_SW-1:0]    part_r [C_LAT];
    logic [C_SW-1:0]    cur_s;
    logic [C_SW-1:0]    add_a_s;
    logic [C_SW-1:0]    add_b_s;
    logic [C_SW-1:0]    fold_res_s;
    logic [C_SW-1:0]    sum_r;
    logic               sum_vld_r;
    logic               busy_r;
    logic               rdy_s;
    logic               accept_s;
    logic               issue_s;
    logic               ret_vld_s;

    // A tag leaves the pipe exactly when slot_r is back at the slot that issued it.
    assign ret_vld_s   = tag_r[C_LAT-1];
    assign slot_inc_s  = (slot_r == LAST_IDX) ? ZERO_IDX : slot_r + ONE_IDX;
    assign phase_inc_s = (phase_r == LAST_IDX) ? ZERO_IDX : phase_r + ONE_IDX;
    assign fold_res_s  = (C_LAT > 1) ? bus.I_add_sum : part_r[ZERO_IDX];

    // Next-state, handshake and adder operand selection
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        rdy_s    = 1'b0;
        accept_s = 1'b0;
        issue_s  = 1'b0;
        add_a_s  = SUM_ZERO;
        add_b_s  = SUM_ZERO;
        cur_s    = ret_vld_s ? bus.I_add_sum : part_r[slot_r];
        case (state_r)
            ST_IDLE: begin
                if (bus.I_start) begin
                    state_s = ST_ACC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                rdy_s    = (cnt_r < len_r);
                accept_s = rdy_s & bus.I_vld;
                if (accept_s) begin
                    issue_s = 1'b1;
                    add_a_s = sext(bus.I_data);
                    add_b_s = cur_s;
                    cnt_s   = cnt_r + CNT_ONE;
                end else begin
                    cnt_s   = cnt_r;
                end
                if (cnt_s == len_r) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_DRAIN: begin
                if (phase_r == LAST_IDX) begin
                    state_s = AFTER_DRAIN;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_FOLD: begin
                // The running fold value is P[0] first, then whatever the adder hands back.
                if (phase_r == ZERO_IDX) begin
                    add_a_s = (fk_r == ONE_IDX) ? part_r[ZERO_IDX] : bus.I_add_sum;
                    add_b_s = part_r[fk_r];
                end else begin
                    add_a_s = SUM_ZERO;
                    add_b_s = SUM_ZERO;
                end
                if ((phase_r == LAST_IDX) && (fk_r == LAST_IDX)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_FOLD;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, group length, accept count, slot pointer and fold step
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_r <= ST_IDLE;
            len_r   <= CNT_ZERO;
            cnt_r   <= CNT_ZERO;
            slot_r  <= ZERO_IDX;
            phase_r <= ZERO_IDX;
            fk_r    <= ZERO_IDX;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            case (state_r)
                ST_IDLE: begin
                    if (bus.I_start) begin
                        len_r <= bus.I_len;
                    end
                    cnt_r   <= CNT_ZERO;
                    slot_r  <= ZERO_IDX;
                    phase_r <= ZERO_IDX;
                    fk_r    <= ONE_IDX;
                end
                ST_ACC: begin
                    slot_r <= slot_inc_s;
                end
                ST_DRAIN: begin
                    slot_r  <= slot_inc_s;
                    phase_r <= phase_inc_s;
                end
                ST_FOLD: begin
                    phase_r <= phase_inc_s;
                    if (phase_r == LAST_IDX) begin
                        fk_r <= fk_r + ONE_IDX;
                    end
                end
                default: begin
                    slot_r <= slot_r;
                end
            endcase
        end
    end

    // Partial-sum slots: cleared per group, refreshed when no new operand takes the slot
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            for (int i = 0; i < C_LAT; i++) begin
                part_r[i] <= SUM_ZERO;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.I_start) begin
                        for (int i = 0; i < C_LAT; i++) begin
                            part_r[i] <= SUM_ZERO;
                        end
                    end
                end
                ST_ACC: begin
                    if (!accept_s) begin
                        part_r[slot_r] <= cur_s;
                    end
                end
                ST_DRAIN: begin
                    if (ret_vld_s) begin
                        part_r[slot_r] <= bus.I_add_sum;
                    end
                end
                default: begin
                    part_r[slot_r] <= part_r[slot_r];
                end
            endcase
        end
    end

    // In-flight tag pipe; reset discards results still inside the adder
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            tag_r <= {C_LAT{1'b0}};
        end else begin
            tag_r[0] <= issue_s;
            for (int i = 1; i < C_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Registered result and status outputs
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            sum_r     <= SUM_ZERO;
            sum_vld_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            busy_r    <= (state_s != ST_IDLE);
            sum_vld_r <= (state_r == ST_DONE);
            if (state_r == ST_DONE) begin
                sum_r <= fold_res_s;
            end
        end
    end

    assign bus.O_rdy     = rdy_s;
    assign bus.O_add_a   = add_a_s;
    assign bus.O_add_b   = add_b_s;
    assign bus.O_sum     = sum_r;
    assign bus.O_sum_vld = sum_vld_r;
    assign bus.O_busy    = busy_r;
endmodule

// File: tb/tb_acc_pp2_sched.sv
// Directed bench for acc_pp2_sched with a behavioural C_LAT-cycle adder attached.
module tb_acc_pp2_sched;
    localparam int C_DW    = 16;
    localparam int C_SW    = 24;
    localparam int C_LAT   = 2;
    localparam int C_CNT_W = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    acc_pp2_sched_if #(.C_DW(C_DW), .C_SW(C_SW), .C_CNT_W(C_CNT_W)) bus ();

    acc_pp2_sched #(
        .C_DW(C_DW), .C_SW(C_SW), .C_LAT(C_LAT), .C_CNT_W(C_CNT_W)
    ) dut (
        .I_clk(clk),
        .I_rst(rst),
        .bus  (bus)
    );

    // Adder model: never reset, so a stale in-flight result really does arrive after a reset
    logic [C_SW-1:0] add_pipe [0:C_LAT-1];
    always @(posedge clk) begin
        add_pipe[0] <= bus.O_add_a + bus.O_add_b;
        for (int i = 1; i < C_LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign bus.I_add_sum = add_pipe[C_LAT-1];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int vld_cnt  = 0;
    int acc_cnt  = 0;
    int vld_cyc  = 0;
    logic [C_SW-1:0] vld_sum = '0;
    int vld_base, acc_base, start_edge, exp_last_edge;
    logic [15:0] smp [0:3];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor sampled mid-cycle: accepts and result pulses
    always @(negedge clk) begin
        if (bus.I_vld && bus.O_rdy) acc_cnt++;
        if (bus.O_sum_vld) begin
            vld_cnt++;
            vld_cyc = cyc;
            vld_sum = bus.O_sum;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_group(input logic [9:0] len);
        bus.I_start = 1'b1;
        bus.I_len   = len;
        start_edge  = cyc + 1;
        vld_base    = vld_cnt;
        acc_base    = acc_cnt;
        tick();
        bus.I_start = 1'b0;
        check_eq("busy_after_start", {31'd0, bus.O_busy}, 32'd1);
    endtask

    task automatic feed(input int n, input logic [15:0] vpat, input int plen, input logic [15:0] spat);
        int idx;
        idx = 0;
        for (int c = 0; c < plen; c++) begin
            bus.I_vld   = vpat[c];
            bus.I_data  = (idx < n) ? smp[idx] : 16'd100;
            bus.I_start = spat[c];
            if (spat[c]) bus.I_len = 10'd3;
            #1;
            if (vpat[c] && idx < n) begin
                check_eq("add_a", {8'd0, bus.O_add_a}, {8'd0, {8{smp[idx][15]}}, smp[idx]});
                if (idx == 0) check_eq("add_b_first", {8'd0, bus.O_add_b}, 32'd0);
                if (idx == n - 1) exp_last_edge = cyc + 1;
                idx++;
            end else begin
                check_eq("add_a_no_issue", {8'd0, bus.O_add_a}, 32'd0);
                if (vpat[c]) check_eq("rdy_after_full", {31'd0, bus.O_rdy}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        bus.I_start = 1'b0;
        bus.I_vld   = 1'b0;
    endtask

    task automatic finish_group(input logic [23:0] exp_sum, input int exp_acc, input int exp_vcyc,
                                input string nm);
        bus.I_vld = 1'b0;
        repeat (20) tick();
        check_eq({nm, "_vld_pulses"}, vld_cnt - vld_base, 32'd1);
        check_eq({nm, "_sum"}, {8'd0, vld_sum}, {8'd0, exp_sum});
        check_eq({nm, "_sum_held"}, {8'd0, bus.O_sum}, {8'd0, exp_sum});
        check_eq({nm, "_accepts"}, acc_cnt - acc_base, exp_acc);
        check_eq({nm, "_vld_cycle"}, vld_cyc, exp_vcyc);
        check_eq({nm, "_busy_end"}, {31'd0, bus.O_busy}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string nm);
        check_eq({nm, "_rdy"},     {31'd0, bus.O_rdy},     32'd0);
        check_eq({nm, "_busy"},    {31'd0, bus.O_busy},    32'd0);
        check_eq({nm, "_sum"},     {8'd0, bus.O_sum},      32'd0);
        check_eq({nm, "_sum_vld"}, {31'd0, bus.O_sum_vld}, 32'd0);
        check_eq({nm, "_add_a"},   {8'd0, bus.O_add_a},    32'd0);
        check_eq({nm, "_add_b"},   {8'd0, bus.O_add_b},    32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        bus.I_start = 1'b0;
        bus.I_len   = 10'd0;
        bus.I_vld   = 1'b0;
        bus.I_data  = 16'd0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Back-to-back 1,2,3,4
        smp[0] = 16'd1; smp[1] = 16'd2; smp[2] = 16'd3; smp[3] = 16'd4;
        start_group(10'd4);
        feed(4, 16'h000F, 4, 16'h0000);
        finish_group(24'd10, 4, exp_last_edge + 5, "t1");

        // Bubbles 1,0,0,1,1,0,1 then one extra valid that must not be consumed
        start_group(10'd4);
        feed(4, 16'h00D9, 8, 16'h0000);
        finish_group(24'd10, 4, exp_last_edge + 5, "t2");

        // Negative extremes wrap in 24 bits
        smp[0] = 16'h8000; smp[1] = 16'h8000;
        start_group(10'd2);
        feed(2, 16'h0003, 2, 16'h0000);
        finish_group(24'hFF0000, 2, exp_last_edge + 5, "t3a");

        smp[0] = 16'h7FFF;
        start_group(10'd1);
        feed(1, 16'h0001, 1, 16'h0000);
        finish_group(24'h007FFF, 1, exp_last_edge + 5, "t3b");

        // Empty group
        start_group(10'd0);
        finish_group(24'd0, 0, start_edge + 6, "t4");

        // Start pulse with len=3 mid-group is ignored
        smp[0] = 16'd1; smp[1] = 16'd2; smp[2] = 16'd3; smp[3] = 16'd4;
        start_group(10'd4);
        feed(4, 16'h000F, 4, 16'h0004);
        finish_group(24'd10, 4, exp_last_edge + 5, "t5");

        // Reset after two of four accepts, then a clean group 5,5
        smp[0] = 16'd7; smp[1] = 16'd9; smp[2] = 16'd11; smp[3] = 16'd13;
        start_group(10'd4);
        feed(4, 16'h0003, 2, 16'h0000);
        bus.I_vld  = 1'b1;
        bus.I_data = 16'd5;
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        #1;
        rst       = 1'b0;
        bus.I_vld = 1'b0;
        smp[0] = 16'd5; smp[1] = 16'd5;
        start_group(10'd2);
        feed(2, 16'h0003, 2, 16'h0000);
        finish_group(24'd10, 2, exp_last_edge + 5, "t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
